// File: rtl/native_mem_pkg.sv
// Shared types for the native memory bus responder: FSM states, credit width
// and the captured request record.
package native_mem_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } nm_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } nm_req_t;

endpackage

// File: rtl/native_mem_responder_if.sv
// Native memory bus between the core (master) and a memory model (slave).
// Handshake: master raises mem_valid with stable addr/wdata/wstrb/instr and
// holds everything until the slave answers with a single-cycle mem_ready pulse.
interface native_mem_responder_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/native_mem_array.sv
// Word storage with a byte-enable bus write port, a full-word backdoor write
// port and one registered read port that doubles as the response data holder.
module native_mem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   wdata,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [31:0]   bd_wdata,
    input  logic          re,
    input  logic          rzero,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = rzero ? 32'h0 : mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Bus lanes are assigned after the backdoor word, so on a same-word
    // collision the enabled bus lanes win and the rest keep backdoor data.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem_q[bd_addr] <= bd_wdata;
        end
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/native_mem_responder.sv
// Memory-side responder for the native bus: latency-credit FSM, request
// capture, protocol / range checks, and the backing word array.
module native_mem_responder
    import native_mem_pkg::*;
#(
    parameter int          WORDS   = 1024,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int          LATENCY = 0,
    parameter int          AW      = $clog2(WORDS)
) (
    input  logic                         clk,
    input  logic                         resetn,
    native_mem_responder_if.slave        bus,
    input  logic                         stall,
    input  logic                         bd_we,
    input  logic [AW-1:0]                bd_addr,
    input  logic [31:0]                  bd_wdata,
    output logic                         proto_err,
    output logic                         oob_err,
    output nm_state_t                    dbg_state
);

    localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);

    nm_state_t         state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    nm_req_t           req_q, req_d;
    logic              proto_q, proto_d;
    logic              oob_q, oob_d;

    nm_req_t           bus_req;
    nm_req_t           act_req;
    logic [31:0]       offset;
    logic              in_oob;
    logic              pending;
    logic              done;
    logic              arr_we;
    logic              arr_re;

    assign bus_req = '{addr:  bus.mem_addr,
                       wdata: bus.mem_wdata,
                       wstrb: bus.mem_wstrb,
                       instr: bus.mem_instr};

    // With zero latency the access completes in the capture cycle, so the
    // live bus fields are used while idle and the captured copy afterwards.
    assign act_req = (state_q == IDLE) ? bus_req : req_q;
    assign offset  = act_req.addr - BASE;
    assign in_oob  = (offset >> (AW + 2)) != 32'h0;

    assign pending = resetn && (((state_q == IDLE) && bus.mem_valid) || (state_q == WAIT));
    assign done    = pending && !stall && (cnt_q == LAT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        proto_d = proto_q;
        oob_d   = oob_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    req_d = bus_req;
                    if (bus_req.addr[1:0] != 2'b00) proto_d = 1'b1;
                    if (in_oob) oob_d = 1'b1;
                    if (done) begin
                        state_d = READY;
                    end else begin
                        state_d = WAIT;
                        if (!stall) cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!bus.mem_valid || (bus_req != req_q)) proto_d = 1'b1;
                if (done) begin
                    state_d = READY;
                end else if (!stall) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            proto_q <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            proto_q <= proto_d;
            oob_q   <= oob_d;
        end
    end

    // Out-of-range writes are dropped; out-of-range reads load zero.
    assign arr_we = done && (act_req.wstrb != 4'b0000) && !in_oob;
    assign arr_re = done && (act_req.wstrb == 4'b0000);

    native_mem_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_array (
        .clk      (clk),
        .rst_n    (resetn),
        .we       (arr_we),
        .waddr    (offset[AW+1:2]),
        .wstrb    (act_req.wstrb),
        .wdata    (act_req.wdata),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .re       (arr_re),
        .rzero    (in_oob),
        .raddr    (offset[AW+1:2]),
        .rdata    (bus.mem_rdata)
    );

    assign bus.mem_ready = (state_q == READY);
    assign proto_err     = proto_q;
    assign oob_err       = oob_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_native_mem_responder.sv
// Directed bench: four responders with LATENCY 0..3 share one stimulus; each
// scenario checks only the instance whose latency it targets.
module tb_native_mem_responder;
    import native_mem_pkg::*;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        stall;
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_wdata;

    logic [3:0]  rdy;
    logic [3:0]  perr;
    logic [3:0]  oerr;
    logic [31:0] rd  [4];
    nm_state_t   dbg [4];

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        native_mem_responder_if bus_i ();
        assign bus_i.mem_valid = valid;
        assign bus_i.mem_instr = instr;
        assign bus_i.mem_addr  = addr;
        assign bus_i.mem_wdata = wdata;
        assign bus_i.mem_wstrb = wstrb;

        native_mem_responder #(
            .WORDS   (1024),
            .BASE    (32'h0000_0000),
            .LATENCY (g)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .bus       (bus_i),
            .stall     (stall),
            .bd_we     (bd_we),
            .bd_addr   (bd_addr),
            .bd_wdata  (bd_wdata),
            .proto_err (perr[g]),
            .oob_err   (oerr[g]),
            .dbg_state (dbg[g])
        );

        assign rdy[g] = bus_i.mem_ready;
        assign rd[g]  = bus_i.mem_rdata;
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        resetn = 1'b0;
        valid  = 1'b0;
        stall  = 1'b0;
        wstrb  = 4'h0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic bd_write(input logic [9:0] idx, input logic [31:0] d);
        @(posedge clk);
        #1;
        bd_we    = 1'b1;
        bd_addr  = idx;
        bd_wdata = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Drives one request starting in a fresh cycle c; lat is the number of
    // cycles from c to the cycle where instance l shows mem_ready.
    task automatic do_req(input int l, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic ins, input logic [7:0] smask,
                          input logic [31:0] chg, output int lat, output logic [31:0] data);
        logic seen;
        @(posedge clk);
        #1;
        valid = 1'b1;
        addr  = a;
        wdata = wd;
        wstrb = ws;
        instr = ins;
        stall = smask[0];
        lat   = 0;
        data  = 32'h0;
        seen  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy[l]) begin
                lat  = k;
                data = rd[l];
                seen = 1'b1;
                break;
            end
            stall = (k < 8) ? smask[k] : 1'b0;
            if (k == 1 && chg != 32'h0) addr = chg;
        end
        valid = 1'b0;
        stall = 1'b0;
        wstrb = 4'h0;
        instr = 1'b0;
        chk("ready_seen", {31'h0, seen}, 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int          lat;
        int          pulses;
        logic [31:0] data;

        resetn = 1'b0; valid = 1'b0; instr = 1'b0; addr = 32'h0; wdata = 32'h0;
        wstrb = 4'h0; stall = 1'b0; bd_we = 1'b0; bd_addr = 10'h0; bd_wdata = 32'h0;
        do_reset();

        chk("rst_ready", {31'h0, rdy[0]}, 32'd0);
        chk("rst_rdata", rd[0], 32'h0);
        chk("rst_proto", {31'h0, perr[0]}, 32'd0);
        chk("rst_oob",   {31'h0, oerr[0]}, 32'd0);
        chk("rst_state", 32'(dbg[0]), 32'(IDLE));

        // LATENCY=0 reads, data and instruction fetch
        bd_write(10'd4, 32'hDEAD_BEEF);
        bd_write(10'd8, 32'hAAAA_AAAA);
        bd_write(10'd0, 32'h0BAD_F00D);
        do_req(0, 32'h10, 32'h0, 4'h0, 1'b0, 8'h00, 32'h0, lat, data);
        chk("l0_lat",  lat, 32'd1);
        chk("l0_data", data, 32'hDEAD_BEEF);
        do_req(0, 32'h10, 32'h0, 4'h0, 1'b1, 8'h00, 32'h0, lat, data);
        chk("l0_ifetch_lat",  lat, 32'd1);
        chk("l0_ifetch_data", data, 32'hDEAD_BEEF);
        chk("l0_proto", {31'h0, perr[0]}, 32'd0);

        // LATENCY=2 byte-lane write, then read back
        do_reset();
        do_req(2, 32'h20, 32'h1122_3344, 4'b0101, 1'b0, 8'h00, 32'h0, lat, data);
        chk("l2_wr_lat", lat, 32'd3);
        chk("l2_wr_rdata_hold", data, 32'h0);
        do_req(2, 32'h20, 32'h0, 4'h0, 1'b0, 8'h00, 32'h0, lat, data);
        chk("l2_rd_lat",  lat, 32'd3);
        chk("l2_rd_data", data, 32'hAA22_AA44);

        // LATENCY=1 with three stalled cycles, then back-to-back
        do_reset();
        do_req(1, 32'h10, 32'h0, 4'h0, 1'b0, 8'b0000_0111, 32'h0, lat, data);
        chk("l1_stall_lat",  lat, 32'd5);
        chk("l1_stall_data", data, 32'hDEAD_BEEF);
        do_req(1, 32'h20, 32'h0, 4'h0, 1'b0, 8'h00, 32'h0, lat, data);
        chk("l1_b2b_lat",  lat, 32'd2);
        chk("l1_b2b_data", data, 32'hAA22_AA44);
        @(posedge clk);
        #1;
        chk("l1_pulse_width", {31'h0, rdy[1]}, 32'd0);

        // Out-of-range read and dropped write
        do_reset();
        do_req(0, 32'h10, 32'h0, 4'h0, 1'b0, 8'h00, 32'h0, lat, data);
        chk("oob_pre_data", data, 32'hDEAD_BEEF);
        do_req(0, 32'h1000, 32'h0, 4'h0, 1'b0, 8'h00, 32'h0, lat, data);
        chk("oob_rd_lat",  lat, 32'd1);
        chk("oob_rd_data", data, 32'h0);
        chk("oob_flag",    {31'h0, oerr[0]}, 32'd1);
        do_req(0, 32'h1000, 32'h1234_5678, 4'hF, 1'b0, 8'h00, 32'h0, lat, data);
        do_req(0, 32'h0, 32'h0, 4'h0, 1'b0, 8'h00, 32'h0, lat, data);
        chk("oob_wr_dropped", data, 32'h0BAD_F00D);

        // Misaligned address
        do_reset();
        do_req(0, 32'h11, 32'h0, 4'h0, 1'b0, 8'h00, 32'h0, lat, data);
        chk("misalign_proto", {31'h0, perr[0]}, 32'd1);
        chk("misalign_oob",   {31'h0, oerr[0]}, 32'd0);
        chk("misalign_data",  data, 32'hDEAD_BEEF);

        // LATENCY=3 clean read, then address changed while waiting
        do_reset();
        do_req(3, 32'h20, 32'h0, 4'h0, 1'b0, 8'h00, 32'h0, lat, data);
        chk("l3_lat",   lat, 32'd4);
        chk("l3_data",  data, 32'hAA22_AA44);
        chk("l3_proto", {31'h0, perr[3]}, 32'd0);
        do_req(3, 32'h10, 32'h0, 4'h0, 1'b0, 8'h00, 32'h20, lat, data);
        chk("chg_lat",   lat, 32'd4);
        chk("chg_data",  data, 32'hDEAD_BEEF);
        chk("chg_proto", {31'h0, perr[3]}, 32'd1);

        // Reset pulsed while a LATENCY=3 write is waiting
        bd_write(10'd12, 32'h5555_5555);
        @(posedge clk);
        #1;
        valid = 1'b1;
        addr  = 32'h30;
        wdata = 32'hFFFF_FFFF;
        wstrb = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_in_wait", 32'(dbg[3]), 32'(WAIT));
        resetn = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'h0;
        #1;
        chk("midrst_state", 32'(dbg[3]), 32'(IDLE));
        chk("midrst_proto", {31'h0, perr[3]}, 32'd0);
        chk("midrst_oob",   {31'h0, oerr[3]}, 32'd0);
        chk("midrst_rdata", rd[3], 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (rdy[3]) pulses++;
        end
        chk("midrst_no_ready", pulses, 32'd0);
        do_req(3, 32'h30, 32'h0, 4'h0, 1'b0, 8'h00, 32'h0, lat, data);
        chk("midrst_word_kept", data, 32'h5555_5555);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/native_mem_responder.md
# native_mem_responder

Memory-side responder for the core's native memory bus (`mem_valid`/`mem_ready`, `mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_rdata`, `mem_instr`), i.e. the far end of the interface the core drives as initiator.

- Serves instruction fetches, loads and byte-lane stores from an internal word array, with configurable and stall-stretchable latency.
- Sticky flags report protocol violations and out-of-range accesses.
- Used as the memory model in core-level benches and formal harnesses.

## Interface
Parameters:
- `WORDS`, 1024, array depth in 32-bit words (power of two, ≥2)
- `BASE`, 32'h0000_0000, byte address of word 0
- `LATENCY`, 0, extra non-stalled wait cycles before `mem_ready` (0..15)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock
- `resetn` in 1: asynchronous active-low reset
- `mem_valid` in 1: request pending
- `mem_instr` in 1: request is an instruction fetch (informational; identical handling)
- `mem_addr` in 32: byte address, word aligned
- `mem_wdata` in 32: store data
- `mem_wstrb` in 4: byte-lane write enables; 0 = read
- `mem_ready` out 1: one-cycle completion pulse
- `mem_rdata` out 32: read data, valid while `mem_ready` is high on a read
- `stall` in 1: when high, the current cycle earns no latency credit (nondeterministic delay for formal)
- `bd_we` in 1: backdoor word write enable
- `bd_addr` in AW (AW = $clog2(WORDS)): backdoor word index
- `bd_wdata` in 32: backdoor write data
- `proto_err` out 1: sticky protocol-violation flag
- `oob_err` out 1: sticky out-of-range flag

## Operation
- States: IDLE, WAIT, READY.
- IDLE:
  - On `mem_valid`, capture `addr`/`wdata`/`wstrb`/`instr`.
  - Go to READY once the credit count is met (see Timing); otherwise go to WAIT.
- WAIT: accumulate credits; go to READY when LATENCY+1 credits are reached.
- Access is performed on the edge entering READY:
  - Read: `mem_rdata` ← word.
  - Write: lanes with `wstrb[i]`=1 update byte i; `mem_rdata` is unchanged.
- READY: `mem_ready`=1 for exactly one cycle, then IDLE unconditionally.
- Index = (`addr` − `BASE`)[AW+1:2]. Out of range when (`addr` − `BASE`) ≥ 4·WORDS, unsigned, so addresses below `BASE` wrap to large values and count as out of range. Out-of-range requests:
  - still complete with normal timing;
  - read returns 32'h0;
  - write is dropped;
  - `oob_err` is set.
- `proto_err` is set when any of the following occurs:
  - `mem_addr[1:0]`≠0 on a captured request;
  - in WAIT, `mem_valid` drops;
  - in WAIT, `addr`/`wdata`/`wstrb`/`instr` differ from the captured values.
- On a violation, the transaction still completes using the captured values.
- Backdoor write: `bd_we` writes the full word on the clock edge in any state. If it hits the same word on the same edge as a bus write, bus-enabled lanes take the bus data and the other lanes take the backdoor data.
- `mem_valid` high in the IDLE cycle after READY is a new request; back-to-back transactions are allowed.

## Timing
- Reset values: state IDLE, `mem_ready` 0, `mem_rdata` 32'h0, `proto_err` 0, `oob_err` 0, credit counter 0. The array is not reset.
- Credit: each cycle with a request pending (first IDLE cycle or WAIT) and `stall`=0.
- `mem_ready` rises the cycle after the (LATENCY+1)-th credit cycle.
- With LATENCY=0 and `stall`=0, `mem_valid` rising in cycle c gives `mem_ready` in cycle c+1.
- Each stalled cycle adds one cycle.
- `mem_rdata` holds its value between read responses.
- `resetn` assertion mid-transaction:
  - immediately forces IDLE and clears `mem_ready`/`mem_rdata`/flags;
  - no array write occurs for an incomplete transaction;
  - array contents are retained.
- Counter width: 4 bits plus terminal compare; no wrap.

## Structure
- Package `native_mem_pkg`:
  - state enum `nm_state_t` {IDLE, WAIT, READY};
  - `LAT_W`=4;
  - request struct `nm_req_t` (`addr`, `wdata`, `wstrb`, `instr`).
- Sub-module `native_mem_array`:
  - WORDS×32 storage;
  - one byte-enable write port plus backdoor write port with the merge priority above;
  - one synchronous read port.
- FSM, capture, credit counter and checks live in `native_mem_responder`.

## Test plan
- LATENCY=0, `stall`=0:
  - backdoor word 4 = 32'hDEADBEEF;
  - read addr 32'h10 in cycle c → `mem_ready` in c+1, `mem_rdata`=32'hDEADBEEF;
  - `mem_instr`=1 gives the same result.
- LATENCY=2:
  - write addr 32'h20, wdata 32'h11223344, wstrb 4'b0101;
  - then read 32'h20 → first word 32'hxx22xx44 with untouched lanes holding prior backdoor value 32'hAAAAAAAA, i.e. 32'hAA22AA44;
  - `mem_ready` 3 cycles after `mem_valid`.
- LATENCY=1, `stall` high for 3 of the first 4 pending cycles → `mem_ready` at c+5, pulse width 1, immediate back-to-back request accepted.
- Read at `BASE`+4·WORDS → `mem_rdata`=0, `oob_err`=1; subsequent write there leaves the array unchanged.
- LATENCY=3, `mem_addr` changed in WAIT → `proto_err`=1, response uses the originally captured address.
- `resetn` pulsed in WAIT of a write → `mem_ready` never pulses, flags 0, target word unchanged.
